// File: rtl/weight_rom_stream_ctrl.sv
// Weight ROM read sequencer: sweeps addresses 0..DEPTH-1 for a programmable number
// of passes and streams the returned words through a credit-managed output FIFO.
module weight_rom_stream_ctrl #(
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 2304,
    parameter int ROM_LATENCY = 2,
    parameter int PASS_WIDTH  = 8,
    parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] passes,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_last,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int BUF_DEPTH = ROM_LATENCY + 2;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
    localparam int INF_W     = $clog2(ROM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [PASS_WIDTH-1:0]   passes_q, passes_d;
    logic [PASS_WIDTH-1:0]   pass_q, pass_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ROM_LATENCY-1:0]  vld_q, vld_d;
    logic [ROM_LATENCY-1:0]  lst_q, lst_d;
    logic [INF_W-1:0]        inflight_q, inflight_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH:0]     mem_q [BUF_DEPTH];
    logic [DATA_WIDTH:0]     mem_d [BUF_DEPTH];

    logic issue, push, pop, addr_last, final_pass, drain_done, credit_ok;

    // Credits count both in-flight reads and buffered words, so a ROM return always has a slot.
    assign credit_ok  = (32'(inflight_q) + 32'(occ_q)) < 32'(BUF_DEPTH);
    assign addr_last  = (addr_q == ADDR_WIDTH'(DEPTH - 1));
    assign final_pass = (pass_q == passes_q - PASS_WIDTH'(1));
    assign push       = vld_q[ROM_LATENCY-1];
    assign pop        = data_out_valid && data_out_ready;
    assign drain_done = (state_q == DRAIN) && (inflight_q == '0) && (occ_q == OCC_W'(1)) && pop;

    assign rom_ce         = 1'b1;
    assign rom_addr       = addr_q;
    assign done           = done_q;
    assign data_out_valid = (occ_q != '0);
    assign data_out       = data_out_valid ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
    assign data_out_last  = data_out_valid ? mem_q[rd_ptr_q][DATA_WIDTH] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && passes != '0) state_d = RUN;
            RUN:     if (issue && addr_last && final_pass) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        issue = (state_q == RUN) && credit_ok;
    end

    always_comb begin
        passes_d   = passes_q;
        pass_d     = pass_q;
        addr_d     = addr_q;
        inflight_d = inflight_q;
        occ_d      = occ_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        done_d     = (state_q == IDLE && start && passes == '0) || drain_done;
        mem_d      = mem_q;
        vld_d[0]   = issue;
        lst_d[0]   = addr_last;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
        end

        if (state_q == IDLE && start && passes != '0) begin
            passes_d = passes;
            pass_d   = '0;
            addr_d   = '0;
        end else if (issue) begin
            addr_d = addr_last ? '0 : addr_q + ADDR_WIDTH'(1);
            if (addr_last && !final_pass) pass_d = pass_q + PASS_WIDTH'(1);
        end

        case ({issue, push})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = {lst_q[ROM_LATENCY-1], rom_q};
            wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    // Clearing the valid pipe on reset discards any ROM returns still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            passes_q   <= '0;
            pass_q     <= '0;
            addr_q     <= '0;
            vld_q      <= '0;
            lst_q      <= '0;
            inflight_q <= '0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            passes_q   <= passes_d;
            pass_q     <= pass_d;
            addr_q     <= addr_d;
            vld_q      <= vld_d;
            lst_q      <= lst_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/weight_rom_stream_ctrl.md
# weight_rom_stream_ctrl

Read sequencer for a weight ROM with fixed read latency: on `start` it sweeps ROM addresses 0..DEPTH-1 a programmable number of times. Returned words go through a small credit-managed buffer and out as a valid/ready stream. It sits between a per-layer weight ROM wrapper (2-cycle registered read, `ce0` tied high) and the downstream linear/matmul core. Consumer backpressure never loses or duplicates a word.

## Interface
- DATA_WIDTH, 128, width of one ROM word / output word
- DEPTH, 2304, ROM words per pass (≥1)
- ROM_LATENCY, 2, cycles from address issue to `rom_q` valid (≥1)
- PASS_WIDTH, 8, width of `passes`
- ADDR_WIDTH, $clog2(DEPTH)+1, ROM address width
- BUF_DEPTH (localparam), ROM_LATENCY+2, output buffer entries

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin job; sampled only in IDLE
- passes  in  PASS_WIDTH  number of full sweeps; sampled with `start`
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at job end
- rom_addr  out  ADDR_WIDTH  read address to ROM
- rom_ce  out  1  tied 1; ROM pipeline always advances
- rom_q  in  DATA_WIDTH  ROM read data
- data_out  out  DATA_WIDTH  buffer head word
- data_out_last  out  1  head word is the last word of its pass
- data_out_valid  out  1  head valid
- data_out_ready  in  1  consumer accepts

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE, start=1, passes≠0: latch passes, clear addr/pass counters, go RUN. If passes=0: stay IDLE, pulse `done` next cycle, issue no reads.
- RUN: issue a read in a cycle when `inflight + occupancy < BUF_DEPTH`.
  - `inflight` = reads issued, data not yet captured (0..ROM_LATENCY).
  - `occupancy` = buffer fill (0..BUF_DEPTH).
  - An issue drives `rom_addr` = addr counter, then increments the counter.
  - At DEPTH-1 the counter wraps to 0 and the pass counter increments.
  - The issue of word DEPTH-1 of the final pass moves to DRAIN.
- Issue tracking: a ROM_LATENCY-stage shift register of {valid, last}. `last` = (addr==DEPTH-1). Stage ROM_LATENCY-1 valid writes `rom_q` plus its `last` into the buffer that cycle.
- Buffer is a FIFO. Head drives `data_out` / `data_out_last`. `data_out_valid` = occupancy≠0. Pop when valid & ready.
- Credit rule guarantees a ROM return always finds a free entry; overflow is impossible by construction.
- DRAIN: no issues. When inflight=0, occupancy=0 and the final word has handshaked, go IDLE and pulse `done` for 1 cycle.
- `start` in RUN/DRAIN is ignored. `passes` changes after start are ignored.
- Counter widths: addr ADDR_WIDTH, pass PASS_WIDTH, occupancy $clog2(BUF_DEPTH+1). No arithmetic overflow is permitted.

## Timing
- Reset values:
  - state IDLE, busy=0, done=0
  - rom_addr=0, rom_ce=1
  - data_out_valid=0, data_out_last=0
  - data_out is don't-care but held at 0
  - inflight and occupancy cleared; in-flight ROM returns discarded
- rst mid-job aborts immediately. No `done` pulse. Next `start` restarts at address 0.
- `busy` rises the cycle after `start` is accepted.
- Read issued in cycle t has its `rom_q` captured at the end of cycle t+ROM_LATENCY and is visible on `data_out` in cycle t+ROM_LATENCY+1. No bypass path.
- First-word latency: start accepted in cycle 0 gives first issue in cycle 1 and data_out_valid in cycle ROM_LATENCY+2 (4 with default).
- With ready held high: one word per cycle sustained, including across pass boundaries.
- Simultaneous buffer push and pop: occupancy unchanged; order preserved.
- `done` is asserted the cycle after the final handshake. IDLE is re-entered that same cycle, so a new `start` is accepted that cycle.
- data_out/data_out_last stay stable while valid & !ready (AXI-style hold).

## Test plan
- DEPTH=8, passes=1, ready=1, ROM word i = i: valid from cycle 4. Values 0..7 on consecutive cycles, last=1 only on 7. done the cycle after 7 handshakes; busy spans cycle 1 to the cycle before done.
- DEPTH=8, passes=3, ready=1: 24 words, sequence 0..7 repeated, last=1 on words 7/15/23, no gap at wraps.
- Random ready at 30% duty, DEPTH=8, passes=2: output exactly 0..7,0..7. occupancy+inflight never exceeds 4. Data stable under stall.
- ready=0 for 20 cycles after start: exactly 4 reads issued, then no issues. Release ready: stream resumes with no loss or duplicate.
- passes=0: no rom issue, busy stays 0, done pulses 1 cycle after start.
- rst asserted mid-pass-2: all outputs at reset values next cycle. Fresh start, passes=1: clean 0..DEPTH-1 with no stale words.
